// File: rtl/path_delay_sequencer.sv
// -----------------------------------------------------------------------------
// path_delay_sequencer
//
// Measures the propagation delay of one of NUM_PATHS chained delay lines. One
// path is selected, left to settle, then sent a transition. The sequencer
// counts clock cycles until the synchronised path output follows. It repeats
// this for a programmed number of runs, alternating the edge polarity, and
// reports the accumulated delay, the number of timed-out runs and the path id.
//
// Optional build macro:
//   MINMAX_EN  adds res_min / res_max, the smallest and largest per-run delay
//              taken over the runs that did not time out.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         measurement request, sampled only in IDLE
//   path_id_in    path to measure, captured together with start
//   runs_in       number of runs, captured together with start (0 means 1)
//   busy          high in every state except IDLE
//   path_sel      registered path select; changes only in IDLE
//   path_launch   registered transition driven into the selected path
//   path_result   selected path output, asynchronous to clk
//   res_valid     result available (held in DONE)
//   res_ready     result consumer ready
//   res_total     sum of per-run delays over runs that did not time out
//   res_timeouts  number of runs that timed out
//   res_path_id   path the result belongs to
//   res_min/max   (MINMAX_EN only) per-run delay extremes
//   state_dbg     current FSM state, for observation only
//
// Result handshake: a result transfers on a cycle where res_valid and
// res_ready are both high. res_* stay stable while res_valid is high and the
// transfer has not happened; res_valid falls on the cycle after the transfer.
// -----------------------------------------------------------------------------
module path_delay_sequencer #(
  parameter int NUM_PATHS  = 4,
  parameter int PATH_W     = 2,
  parameter int CNT_W      = 8,
  parameter int RUN_W      = 4,
  parameter int TIMEOUT    = 200,
  parameter int SETTLE_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PATH_W-1:0]      path_id_in,
  input  logic [RUN_W-1:0]       runs_in,
  output logic                   busy,
  output logic [PATH_W-1:0]      path_sel,
  output logic                   path_launch,
  input  logic                   path_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CNT_W+RUN_W-1:0] res_total,
  output logic [RUN_W-1:0]       res_timeouts,
  output logic [PATH_W-1:0]      res_path_id,
`ifdef MINMAX_EN
  output logic [CNT_W-1:0]       res_min,
  output logic [CNT_W-1:0]       res_max,
`endif
  output logic [2:0]             state_dbg
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = CNT_W + RUN_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RECORD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic              res_s1, res_s;
  logic [RUN_W-1:0]  runs, run_idx, timeouts;
  logic [SW-1:0]     settle_cnt;
  logic [CNT_W-1:0]  cnt, delay;
  logic              timed_out;
  logic [TW-1:0]     total;
  logic              match, settle_end, run_last;
`ifdef MINMAX_EN
  logic [CNT_W-1:0]  min_q, max_q;
`endif

  // Path output reaches us through two flops; their latency is part of the
  // reported delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_s1 <= 1'b0;
      res_s  <= 1'b0;
    end else begin
      res_s1 <= path_result;
      res_s  <= res_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    match      = (res_s == path_launch);
    settle_end = (settle_cnt == SW'(SETTLE_CYC - 1));
    run_last   = ((run_idx + RUN_W'(1)) == runs);
    case (state)
      S_IDLE:   if (start) state_next = S_SETTLE;
      S_SETTLE: if (settle_end && match) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT:   if (match || (cnt == CNT_W'(TIMEOUT))) state_next = S_RECORD;
      S_RECORD: state_next = run_last ? S_DONE : S_SETTLE;
      S_DONE:   if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_sel    <= '0;
      path_launch <= 1'b0;
      runs        <= '0;
      run_idx     <= '0;
      timeouts    <= '0;
      settle_cnt  <= '0;
      cnt         <= '0;
      delay       <= '0;
      timed_out   <= 1'b0;
      total       <= '0;
`ifdef MINMAX_EN
      min_q       <= '1;
      max_q       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            path_sel   <= path_id_in;
            runs       <= (runs_in == '0) ? RUN_W'(1) : runs_in;
            run_idx    <= '0;
            timeouts   <= '0;
            total      <= '0;
            settle_cnt <= '0;
`ifdef MINMAX_EN
            min_q      <= '1;
            max_q      <= '0;
`endif
          end
        end
        S_SETTLE: begin
          // At the end of the window the count restarts whether or not the
          // path was quiet; a noisy path simply gets another full window.
          if (settle_end) settle_cnt <= '0;
          else            settle_cnt <= settle_cnt + SW'(1);
        end
        S_LAUNCH: begin
          path_launch <= ~path_launch;
          cnt         <= CNT_W'(1);
        end
        S_WAIT: begin
          if (match) begin
            delay     <= cnt;
            timed_out <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            timeouts  <= timeouts + RUN_W'(1);
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RECORD: begin
          if (!timed_out) begin
            total <= total + TW'(delay);
`ifdef MINMAX_EN
            if (delay < min_q) min_q <= delay;
            if (delay > max_q) max_q <= delay;
`endif
          end
          run_idx    <= run_idx + RUN_W'(1);
          settle_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign res_valid    = (state == S_DONE);
  assign res_total    = total;
  assign res_timeouts = timeouts;
  assign res_path_id  = path_sel;
  assign state_dbg    = state;
`ifdef MINMAX_EN
  assign res_min      = min_q;
  assign res_max      = max_q;
`endif

endmodule

// File: tb/tb_path_delay_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for path_delay_sequencer. The path model is a shift register
// of path_launch: with dly = D, path_result follows path_launch D-1 clock
// edges later, so the sequencer should report D+2 per run (two synchroniser
// flops). With mute set, path_result refuses to follow while the sequencer is
// waiting, so every run times out.
// -----------------------------------------------------------------------------
module tb_path_delay_sequencer;

  localparam int PATH_W = 2;
  localparam int CNT_W  = 8;
  localparam int RUN_W  = 4;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RECORD = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [PATH_W-1:0]      path_id_in = '0;
  logic [RUN_W-1:0]       runs_in = '0;
  logic                   busy;
  logic [PATH_W-1:0]      path_sel;
  logic                   path_launch;
  logic                   path_result;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic [CNT_W+RUN_W-1:0] res_total;
  logic [RUN_W-1:0]       res_timeouts;
  logic [PATH_W-1:0]      res_path_id;
  logic [2:0]             state_dbg;
`ifdef MINMAX_EN
  logic [CNT_W-1:0]       res_min, res_max;
`endif

  int vectors = 0;
  int miscompares = 0;
  int dly = 5;
  logic mute = 1'b0;
  logic [15:0] pipe = '0;

  path_delay_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .path_id_in(path_id_in),
    .runs_in(runs_in), .busy(busy), .path_sel(path_sel),
    .path_launch(path_launch), .path_result(path_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_total(res_total),
    .res_timeouts(res_timeouts), .res_path_id(res_path_id),
`ifdef MINMAX_EN
    .res_min(res_min), .res_max(res_max),
`endif
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // path model
  always @(posedge clk) pipe <= {pipe[14:0], path_launch};
  always_comb begin
    path_result = path_launch;
    if (mute)
      path_result = (state_dbg == ST_WAIT) ? ~path_launch : path_launch;
    else if (dly > 1)
      path_result = pipe[dly-2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag);
    int n = 0;
    while (state_dbg !== s && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {29'd0, state_dbg}, {29'd0, s});
  endtask

  task automatic kick(input logic [PATH_W-1:0] p, input logic [RUN_W-1:0] r);
    path_id_in = p;
    runs_in    = r;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", {31'd0, res_valid}, 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_launch", {31'd0, path_launch}, 0);
    check("rst_sel", {30'd0, path_sel}, 0);
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_total", {20'd0, res_total}, 0);
    check("rst_tmo", {28'd0, res_timeouts}, 0);
`ifdef MINMAX_EN
    check("rst_min", {24'd0, res_min}, 255);
    check("rst_max", {24'd0, res_max}, 0);
`endif

    // 1: delay 5, path 2, 4 runs -> 4 x 7
    dly = 5;
    kick(2'd2, 4'd4);
    check("t1_busy", {31'd0, busy}, 1);
    wait_state(ST_DONE, 400, "t1_done");
    check("t1_total", {20'd0, res_total}, 28);
    check("t1_tmo", {28'd0, res_timeouts}, 0);
    check("t1_pid", {30'd0, res_path_id}, 2);
    check("t1_sel", {30'd0, path_sel}, 2);
    check("t1_valid", {31'd0, res_valid}, 1);
    accept();

    // 2: no response, 3 runs; DONE exactly 3 x (16+1+200+1) edges after start
    mute = 1'b1;
    path_id_in = 2'd1;
    runs_in    = 4'd3;
    start      = 1'b1;
    for (int i = 0; i < 654; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t2_not_yet", {31'd0, res_valid}, 0);
    @(negedge clk);
    check("t2_on_time", {31'd0, res_valid}, 1);
    check("t2_total", {20'd0, res_total}, 0);
    check("t2_tmo", {28'd0, res_timeouts}, 3);
    check("t2_pid", {30'd0, res_path_id}, 1);
`ifdef MINMAX_EN
    check("t2_min", {24'd0, res_min}, 255);
    check("t2_max", {24'd0, res_max}, 0);
`endif
    accept();
    mute = 1'b0;

    // 3: runs_in = 0 counts as one run, delay 3 -> 5
    dly = 3;
    kick(2'd3, 4'd0);
    wait_state(ST_DONE, 100, "t3_done");
    check("t3_total", {20'd0, res_total}, 5);
    check("t3_tmo", {28'd0, res_timeouts}, 0);
    check("t3_pid", {30'd0, res_path_id}, 3);

    // 4: stall the consumer; result must hold, start must be ignored
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, res_valid}, 1);
      check("t4_hold_total", {20'd0, res_total}, 5);
    end
    kick(2'd0, 4'd5);
    check("t4_ign_pid", {30'd0, res_path_id}, 3);
    check("t4_ign_valid", {31'd0, res_valid}, 1);
    // start coincident with the handshake is also ignored
    path_id_in = 2'd0;
    start      = 1'b1;
    res_ready  = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    res_ready  = 1'b0;
    check("t4_hs_idle", {31'd0, busy}, 0);
    check("t4_hs_valid", {31'd0, res_valid}, 0);
    @(negedge clk);
    check("t4_still_idle", {31'd0, busy}, 0);

    // 5: reset during the wait of run 2, then a clean measurement
    dly = 10;
    kick(2'd1, 4'd3);
    wait_state(ST_WAIT, 100, "t5_wait1");
    wait_state(ST_RECORD, 100, "t5_rec1");
    wait_state(ST_WAIT, 100, "t5_wait2");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_launch", {31'd0, path_launch}, 0);
    check("t5_sel", {30'd0, path_sel}, 0);
    check("t5_total", {20'd0, res_total}, 0);
    check("t5_valid", {31'd0, res_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dly = 4;
    kick(2'd1, 4'd2);
    wait_state(ST_DONE, 200, "t5_done");
    check("t5_new_total", {20'd0, res_total}, 12);
    check("t5_new_tmo", {28'd0, res_timeouts}, 0);
    check("t5_new_pid", {30'd0, res_path_id}, 1);
    accept();

`ifdef MINMAX_EN
    // 6: delays 3, 9, 6 -> per-run 5, 11, 8
    dly = 3;
    kick(2'd0, 4'd3);
    wait_state(ST_WAIT, 100, "t6_wait1");
    wait_state(ST_RECORD, 100, "t6_rec1");
    dly = 9;
    wait_state(ST_WAIT, 100, "t6_wait2");
    wait_state(ST_RECORD, 100, "t6_rec2");
    dly = 6;
    wait_state(ST_DONE, 200, "t6_done");
    check("t6_min", {24'd0, res_min}, 5);
    check("t6_max", {24'd0, res_max}, 11);
    check("t6_total", {20'd0, res_total}, 24);
    accept();
`endif

    wait_state(ST_IDLE, 5, "final_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
